// File: rtl/ring_counter_gen.sv
// Parametrised ring/Johnson sequence generator with step prescaler, parallel load and status pulses.
// Optional illegal-pattern self-correction is enabled by defining RING_COUNTER_GEN_SELFCORR_EN.
module ring_counter_gen #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             sys_rst_n,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             dir_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] counter_o,
    output logic             tick_o,
    output logic             wrap_o,
    output logic             err_o
);

    localparam logic [WIDTH-1:0] SEED    = WIDTH'(1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    logic [WIDTH-1:0] counter_q, counter_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rot;
    logic             illegal;

    always_comb begin
        unique case ({mode_i, dir_i})
            2'b00:   rot = {counter_q[WIDTH-2:0], counter_q[WIDTH-1]};
            2'b01:   rot = {counter_q[0], counter_q[WIDTH-1:1]};
            2'b10:   rot = {counter_q[WIDTH-2:0], ~counter_q[WIDTH-1]};
            default: rot = {~counter_q[0], counter_q[WIDTH-1:1]};
        endcase
    end

`ifdef RING_COUNTER_GEN_SELFCORR_EN
    localparam logic [WIDTH-2:0] ONE_L = (WIDTH-1)'(1);
    logic [WIDTH-2:0] edges;
    logic             ring_ok, john_ok;

    // Johnson legality: adjacent-bit transitions form at most a single set bit.
    always_comb begin
        edges   = counter_q[WIDTH-2:0] ^ counter_q[WIDTH-1:1];
        ring_ok = (counter_q != '0) && ((counter_q & (counter_q - SEED)) == '0);
        john_ok = (edges & (edges - ONE_L)) == '0;
        illegal = mode_i ? !john_ok : !ring_ok;
    end
`else
    assign illegal = 1'b0;
`endif

    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        counter_d = counter_q;
        div_cnt_d = div_cnt_q;
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        err_d     = 1'b0;
        if (load_i) begin
            counter_d = load_val_i;
            div_cnt_d = '0;
        end else if (en_i) begin
            if (div_cnt_q >= div_i) begin
                div_cnt_d = '0;
                tick_d    = 1'b1;
                if (illegal) begin
                    counter_d = SEED;
                    err_d     = 1'b1;
                end else begin
                    counter_d = rot;
                    wrap_d    = (rot == SEED);
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_ONE;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            counter_q <= SEED;
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
        end
    end

    assign counter_o = counter_q;
    assign tick_o    = tick_q;
    assign wrap_o    = wrap_q;
    assign err_o     = err_q;

endmodule

// File: doc/ring_counter_gen.md
# ring_counter_gen

Parametrised ring/Johnson counter. It generalises the fixed 8-bit one-hot rotator to any width, adds a runtime mode (ring or Johnson), rotation direction, enable, a programmable step prescaler, parallel load and status pulses. It sits alongside the existing counter blocks as a sequence generator for LED/scan drivers and phase-select logic on the FPGA top level.

## Interface
- `WIDTH`, 8, counter width in bits (≥2)
- `DIV_W`, 16, prescaler width in bits (≥1)

- `clk_i`  in  1  clock, rising edge
- `sys_rst_n`  in  1  reset, asynchronous, active-low
- `en_i`  in  1  count enable; low freezes counter and prescaler
- `mode_i`  in  1  0 = ring (one-hot rotate), 1 = Johnson (twisted ring)
- `dir_i`  in  1  0 = shift toward MSB, 1 = shift toward LSB
- `div_i`  in  DIV_W  step every div_i+1 enabled cycles
- `load_i`  in  1  synchronous parallel load strobe
- `load_val_i`  in  WIDTH  value loaded by load_i
- `counter_o`  out  WIDTH  registered counter pattern
- `tick_o`  out  1  one-cycle pulse on every step
- `wrap_o`  out  1  one-cycle pulse when a normal step produces the seed pattern
- `err_o`  out  1  one-cycle pulse when an illegal pattern is corrected (see Configuration)

## Operation
- Seed pattern is WIDTH'b1. On reset: `counter_o` = seed, internal div_cnt = 0, and `tick_o`/`wrap_o`/`err_o` = 0.
- Prescaler: div_cnt is an unsigned DIV_W counter.
  - When en_i = 1 and div_cnt ≥ div_i, the cycle is a step cycle and div_cnt clears to 0.
  - Otherwise, with en_i = 1, div_cnt increments.
  - When en_i = 0, div_cnt holds.
  - Because the comparison is ≥, lowering div_i mid-count steps on the next enabled cycle.
- Step rules (the new value is registered at the edge ending the step cycle):
  - Ring, dir 0: `{c[W-2:0], c[W-1]}`
  - Ring, dir 1: `{c[0], c[W-1:1]}`
  - Johnson, dir 0: `{c[W-2:0], ~c[W-1]}`
  - Johnson, dir 1: `{~c[0], c[W-1:1]}`
- Sequence period: WIDTH steps in ring mode, 2·WIDTH steps in Johnson mode. mode_i and dir_i are sampled only on step cycles, so a change takes effect on the next step with no reset of the pattern.
- Load: load_i = 1 loads load_val_i and clears div_cnt, regardless of en_i.
  - Load has priority over a coincident step; that step is discarded.
  - tick_o, wrap_o and err_o are 0 for the load edge.
  - The loaded value is not legality-checked until the next step.
- tick_o = 1 for exactly the cycle following each step edge, including correction steps.
- wrap_o = 1 with the step whose result equals the seed, in either direction. It is never set by load or by correction.
- Legal patterns:
  - Ring: exactly one bit set.
  - Johnson: at most one position i in 0..W-2 where c[i] ≠ c[i+1].

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Latency: a step condition sampled at edge k appears on `counter_o` and `tick_o` after edge k.
- With en_i held high and div_i = N, steps occur every N+1 cycles; div_i = 0 steps every cycle.
- Reset mid-operation asserts immediately, without waiting for clk_i. The first step after release occurs after div_i+1 enabled cycles.
- Simultaneous load_i and step: load wins. Simultaneous load_i and en_i = 0: load still occurs.

## Configuration
- Macro: `RING_COUNTER_GEN_SELFCORR_EN`.
- Defined: on a step cycle where the current pattern is illegal for mode_i, `counter_o` is set to the seed instead of the rotated value. err_o and tick_o pulse; wrap_o stays 0.
- Undefined: no legality check. Illegal patterns rotate per the step rules, and err_o is tied to 0.

## Test plan
- Reset, WIDTH = 8, ring, dir 0, div 0, en 1: counter_o goes 01, 02, 04, …, 80, 01. tick_o is high every cycle, and wrap_o pulses once each time 01 reappears (every 8 steps).
- Johnson, dir 0, div 0: 01, 03, 07, 0F, 1F, 3F, 7F, FF, FE, FC, …, 80, 00, 01 (period 16). Switching dir to 1 at FF gives 7F as the next value.
- div_i = 3: counter_o changes every 4 cycles. Dropping en_i for 10 cycles freezes counter_o and the prescaler phase. Lowering div_i from 3 to 1 while div_cnt = 2 gives a step on the next cycle.
- With the macro defined: ring mode, load 0x81, then the next step gives 01 with err_o = 1, tick_o = 1 and wrap_o = 0. Without the macro: 0x03 and err_o = 0.
- Load 0x10 on the same cycle as a step: counter_o = 10 and tick_o = 0. Asserting sys_rst_n low mid-run sets counter_o = 01 before the next clk_i edge.
